// File: rtl/dcr_pkg.sv
// Shared definitions for the device-control register file: register map, CTRL action bits, launch FSM states.
package dcr_pkg;

  localparam int DCR_THREAD_COUNT = 0;
  localparam int DCR_BLOCK_SIZE   = 1;
  localparam int DCR_KERNEL_BASE  = 2;
  localparam int DCR_CTRL         = 3;
  localparam int DCR_STATUS       = 4;

  localparam int CTRL_START    = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_CLR_ERR  = 2;

  typedef enum logic [1:0] {
    DCR_IDLE    = 2'd0,
    DCR_RUNNING = 2'd1,
    DCR_DONE    = 2'd2
  } dcr_state_t;

endpackage

// File: rtl/dcr_launch_fsm.sv
// Kernel launch sequencer IDLE -> RUNNING -> DONE; launch is registered, err_set is a same-cycle pulse.
module dcr_launch_fsm
  import dcr_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clear_done,
  input  logic       dispatch_done,
  input  logic       tc_nonzero,
  output dcr_state_t state,
  output logic       launch,
  output logic       err_set
);

  dcr_state_t state_next;
  logic       launch_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= DCR_IDLE;
      launch <= 1'b0;
    end else begin
      state  <= state_next;
      launch <= launch_next;
    end
  end

  always_comb begin
    state_next  = state;
    launch_next = 1'b0;
    err_set     = 1'b0;
    case (state)
      DCR_IDLE: begin
        if (start) begin
          if (tc_nonzero) begin
            state_next  = DCR_RUNNING;
            launch_next = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      DCR_RUNNING: begin
        if (start) err_set = 1'b1;
        if (dispatch_done) state_next = DCR_DONE;
      end
      DCR_DONE: begin
        // A start request takes priority; clear_done only acts on its own.
        if (start) begin
          if (tc_nonzero) begin
            state_next  = DCR_RUNNING;
            launch_next = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end else if (clear_done) begin
          state_next = DCR_IDLE;
        end
      end
      default: state_next = DCR_IDLE;
    endcase
  end

endmodule

// File: rtl/device_control_regfile.sv
// Host-addressable launch-config register file driving the dispatcher, with status readback and sticky error.
// Optional DCR_SHADOW_EN: config writes land in shadow copies that become active on launch.
module device_control_regfile
  import dcr_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] thread_count,
  output logic [DATA_W-1:0] block_size,
  output logic [DATA_W-1:0] kernel_base,
  output logic              launch,
  input  logic              dispatch_done,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  localparam logic [ADDR_W-1:0] A_TC     = ADDR_W'(DCR_THREAD_COUNT);
  localparam logic [ADDR_W-1:0] A_BS     = ADDR_W'(DCR_BLOCK_SIZE);
  localparam logic [ADDR_W-1:0] A_KB     = ADDR_W'(DCR_KERNEL_BASE);
  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(DCR_CTRL);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(DCR_STATUS);

  dcr_state_t state;
  logic       ctrl_wr, start, clear_done, clear_err;
  logic       cfg_wr, unmapped_wr, cfg_drop;
  logic       running, tc_nonzero, fsm_err;
  logic       err_set_any;

  logic [DATA_W-1:0] rd_tc, rd_bs, rd_kb, rd_mux;

  assign ctrl_wr     = wr_en && (wr_addr == A_CTRL);
  assign start       = ctrl_wr && wr_data[CTRL_START];
  assign clear_done  = ctrl_wr && wr_data[CTRL_CLR_DONE];
  assign clear_err   = ctrl_wr && wr_data[CTRL_CLR_ERR];
  assign cfg_wr      = wr_en && (wr_addr <= A_KB);
  assign unmapped_wr = wr_en && (wr_addr > A_STATUS);
  assign running     = (state == DCR_RUNNING);

  dcr_launch_fsm u_fsm (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .clear_done    (clear_done),
    .dispatch_done (dispatch_done),
    .tc_nonzero    (tc_nonzero),
    .state         (state),
    .launch        (launch),
    .err_set       (fsm_err)
  );

`ifdef DCR_SHADOW_EN
  logic [DATA_W-1:0] sh_tc, sh_bs, sh_kb;
  logic              launch_go;

  // Mirrors the FSM's launch decision so the active copy is loaded on the same edge launch rises.
  assign launch_go  = start && !running && (|sh_tc);
  assign tc_nonzero = |sh_tc;
  assign cfg_drop   = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_tc <= '0;
      sh_bs <= '0;
      sh_kb <= '0;
    end else if (cfg_wr) begin
      case (wr_addr)
        A_TC:    sh_tc <= wr_data;
        A_BS:    sh_bs <= wr_data;
        A_KB:    sh_kb <= wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      thread_count <= '0;
      block_size   <= '0;
      kernel_base  <= '0;
    end else if (launch_go) begin
      thread_count <= sh_tc;
      block_size   <= sh_bs;
      kernel_base  <= sh_kb;
    end
  end

  assign rd_tc = sh_tc;
  assign rd_bs = sh_bs;
  assign rd_kb = sh_kb;
`else
  assign tc_nonzero = |thread_count;
  assign cfg_drop   = cfg_wr && running;

  always_ff @(posedge clk) begin
    if (reset) begin
      thread_count <= '0;
      block_size   <= '0;
      kernel_base  <= '0;
    end else if (cfg_wr && !running) begin
      case (wr_addr)
        A_TC:    thread_count <= wr_data;
        A_BS:    block_size   <= wr_data;
        A_KB:    kernel_base  <= wr_data;
        default: ;
      endcase
    end
  end

  assign rd_tc = thread_count;
  assign rd_bs = block_size;
  assign rd_kb = kernel_base;
`endif

  assign busy = running;
  assign done = (state == DCR_DONE);

  assign err_set_any = fsm_err || unmapped_wr || cfg_drop;

  // Set beats clear when both land in one cycle.
  always_ff @(posedge clk) begin
    if (reset)            wr_err <= 1'b0;
    else if (err_set_any) wr_err <= 1'b1;
    else if (clear_err)   wr_err <= 1'b0;
  end

  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      A_TC:     rd_mux = rd_tc;
      A_BS:     rd_mux = rd_bs;
      A_KB:     rd_mux = rd_kb;
      A_STATUS: rd_mux = DATA_W'({wr_err, done, busy});
      default:  rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_data  <= rd_en ? rd_mux : '0;
    end
  end

endmodule
